// File: rtl/fnd_page_scanner_pkg.sv
// Shared constants and helpers for the paged, multiplexed seven-segment scanner.
// Helpers are sized for the widest legal build (8 digits, 4 pages).
package fnd_page_scanner_pkg;

    localparam logic [7:0] SEG_BLANK  = 8'hFF;
    localparam int         MAX_DIGITS = 8;
    localparam int         MAX_PAGES  = 4;

    function automatic logic [MAX_DIGITS-1:0] digit_an(input logic [2:0] idx);
        logic [MAX_DIGITS-1:0] an;
        an      = '1;
        an[idx] = 1'b0;
        return an;
    endfunction

    // Walks downward so the closest enabled page above cur (cyclically) wins; cur if none.
    function automatic logic [1:0] next_page(input logic [MAX_PAGES-1:0] en,
                                             input logic [1:0] cur,
                                             input int pages);
        logic [1:0] res;
        int         p;
        res = cur;
        for (int k = MAX_PAGES - 1; k >= 1; k--) begin
            if (k < pages) begin
                p = (int'(cur) + k) % pages;
                if (en[p[1:0]]) res = p[1:0];
            end
        end
        return res;
    endfunction

endpackage

// File: rtl/fnd_tick_div.sv
// Free-running modulo-N counter with a terminal-count pulse on the last count.
module fnd_tick_div #(
    parameter  int N = 4,
    localparam int W = (N > 1) ? $clog2(N) : 1
) (
    input  logic         clk,
    input  logic         rst_n,
    output logic [W-1:0] count,
    output logic         tc
);

    logic [W-1:0] cnt_q, cnt_d;

    always_comb begin
        tc    = (cnt_q == W'(N - 1));
        cnt_d = tc ? '0 : cnt_q + 1'b1;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) cnt_q <= '0;
        else        cnt_q <= cnt_d;
    end

    assign count = cnt_q;

endmodule

// File: rtl/fnd_page_scanner.sv
// Multiplexed seven-segment driver that rotates through enabled pages of digit codes,
// with anti-ghost blanking, per-digit blink, page jump requests and hold.
module fnd_page_scanner
    import fnd_page_scanner_pkg::*;
#(
    parameter  int DIGITS    = 4,
    parameter  int PAGES     = 2,
    parameter  int SCAN_DIV  = 100_000,
    parameter  int BLANK_CYC = 16,
    parameter  int SEC_DIV   = 100_000_000,
    parameter  int BLINK_DIV = 50_000_000,
    localparam int PW        = (PAGES > 1) ? $clog2(PAGES) : 1,
    localparam int DW        = $clog2(DIGITS),
    localparam int SW        = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1,
    localparam int TW        = (SEC_DIV > 1) ? $clog2(SEC_DIV) : 1,
    localparam int BW        = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic [PAGES*DIGITS*8-1:0]  page_seg,
    input  logic [PAGES-1:0]           page_en,
    input  logic [3:0]                 dwell_sec,
    input  logic                       hold,
    input  logic                       page_sel_valid,
    input  logic [PW-1:0]              page_sel,
    input  logic [DIGITS-1:0]          blink_mask,
    output logic [7:0]                 seg,
    output logic [DIGITS-1:0]          an,
    output logic [PW-1:0]              cur_page,
    output logic                       page_changed
);

    logic [SW-1:0] scan_cnt;
    logic          scan_tc, tick_tc, blink_tc;
    logic [TW-1:0] tick_cnt_unused;
    logic [BW-1:0] blink_cnt_unused;

    fnd_tick_div #(.N(SCAN_DIV))  u_scan  (.clk(clk), .rst_n(rst_n), .count(scan_cnt),         .tc(scan_tc));
    fnd_tick_div #(.N(SEC_DIV))   u_tick  (.clk(clk), .rst_n(rst_n), .count(tick_cnt_unused),  .tc(tick_tc));
    fnd_tick_div #(.N(BLINK_DIV)) u_blink (.clk(clk), .rst_n(rst_n), .count(blink_cnt_unused), .tc(blink_tc));

    logic [DW-1:0]     digit_q, digit_d;
    logic              blink_q, blink_d;
    logic [PW-1:0]     cur_page_q, cur_page_d;
    logic [3:0]        dwell_q, dwell_d;
    logic              page_changed_q, page_changed_d;
    logic [7:0]        seg_q, seg_d;
    logic [DIGITS-1:0] an_q, an_d;

    logic [MAX_PAGES-1:0]  en_ext;
    logic [3:0]            dwell_lim;
    logic [PW-1:0]         nxt_page;
    logic                  any_en, sel_ok, cur_ok, blank;
    logic [MAX_DIGITS-1:0] an_full;

    always_comb begin
        digit_d = digit_q;
        if (scan_tc) digit_d = (digit_q == DW'(DIGITS - 1)) ? '0 : digit_q + 1'b1;
        blink_d = blink_tc ? ~blink_q : blink_q;
    end

    // Page selection: jump request beats disabled-page recovery, which beats dwell expiry.
    always_comb begin
        en_ext         = MAX_PAGES'(page_en);
        any_en         = |page_en;
        sel_ok         = page_sel_valid && en_ext[2'(page_sel)];
        cur_ok         = en_ext[2'(cur_page_q)];
        dwell_lim      = (dwell_sec == 4'd0) ? 4'd1 : dwell_sec;
        nxt_page       = PW'(next_page(en_ext, 2'(cur_page_q), PAGES));
        cur_page_d     = cur_page_q;
        dwell_d        = dwell_q;
        if (sel_ok) begin
            cur_page_d = page_sel;
            dwell_d    = '0;
        end else if (!any_en) begin
            dwell_d    = '0;
        end else if (!cur_ok) begin
            cur_page_d = nxt_page;
            dwell_d    = '0;
        end else if (tick_tc && !hold) begin
            if (dwell_q == dwell_lim - 4'd1) begin
                cur_page_d = nxt_page;
                dwell_d    = '0;
            end else begin
                dwell_d    = dwell_q + 4'd1;
            end
        end
        page_changed_d = (cur_page_d != cur_page_q);
    end

    always_comb begin
        an_full = digit_an(3'(digit_q));
        blank   = (int'(scan_cnt) < BLANK_CYC) || !any_en || (blink_q && blink_mask[digit_q]);
        seg_d   = blank ? SEG_BLANK : page_seg[(int'(cur_page_q) * DIGITS + int'(digit_q)) * 8 +: 8];
        an_d    = blank ? '1 : an_full[DIGITS-1:0];
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            digit_q        <= '0;
            blink_q        <= 1'b0;
            cur_page_q     <= '0;
            dwell_q        <= '0;
            page_changed_q <= 1'b0;
            seg_q          <= SEG_BLANK;
            an_q           <= '1;
        end else begin
            digit_q        <= digit_d;
            blink_q        <= blink_d;
            cur_page_q     <= cur_page_d;
            dwell_q        <= dwell_d;
            page_changed_q <= page_changed_d;
            seg_q          <= seg_d;
            an_q           <= an_d;
        end
    end

    assign seg          = seg_q;
    assign an           = an_q;
    assign cur_page     = cur_page_q;
    assign page_changed = page_changed_q;

endmodule

// File: tb/tb_fnd_page_scanner.sv
// Scoreboard bench for fnd_page_scanner: a cycle-level reference model predicts every output word.
module tb_fnd_page_scanner;

    localparam int DIGITS = 4, PAGES = 3, SCAN_DIV = 4, BLANK_CYC = 1, SEC_DIV = 10, BLINK_DIV = 8;

    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic [95:0] page_seg;
    logic [2:0]  page_en;
    logic [3:0]  dwell_sec;
    logic        hold, page_sel_valid;
    logic [1:0]  page_sel;
    logic [3:0]  blink_mask;
    logic [7:0]  seg;
    logic [3:0]  an;
    logic [1:0]  cur_page;
    logic        page_changed;

    fnd_page_scanner #(
        .DIGITS(DIGITS), .PAGES(PAGES), .SCAN_DIV(SCAN_DIV), .BLANK_CYC(BLANK_CYC),
        .SEC_DIV(SEC_DIV), .BLINK_DIV(BLINK_DIV)
    ) dut (
        .clk(clk), .rst_n(rst_n), .page_seg(page_seg), .page_en(page_en), .dwell_sec(dwell_sec),
        .hold(hold), .page_sel_valid(page_sel_valid), .page_sel(page_sel), .blink_mask(blink_mask),
        .seg(seg), .an(an), .cur_page(cur_page), .page_changed(page_changed)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [7:0] seg;
        logic [3:0] an;
        logic [1:0] page;
        logic       chg;
    } exp_t;

    exp_t exp_q[$];
    int   checks = 0;
    int   errors = 0;
    int   pops   = 0;

    task automatic check(input string name, input int act, input int expv);
        checks++;
        if (act !== expv) begin
            errors++;
            $display("FAIL %s @%0t got %0h expected %0h", name, $time, act, expv);
        end
    endtask

    function automatic int next_en(input int cur, input logic [2:0] en);
        for (int k = 1; k < PAGES; k++)
            if (en[(cur + k) % PAGES]) return (cur + k) % PAGES;
        return cur;
    endfunction

    // Reference model: t counts clock edges since reset release, so every
    // free-running divider position is plain arithmetic on t.
    initial begin
        int   t, mpage, mdwell, old, cnt, dig, bl, lim;
        logic blank;
        exp_t e;
        t = 0; mpage = 0; mdwell = 0;
        forever begin
            @(posedge clk);
            if (!rst_n) begin
                t = 0; mpage = 0; mdwell = 0;
                exp_q.delete();
            end else begin
                cnt   = t % SCAN_DIV;
                dig   = (t / SCAN_DIV) % DIGITS;
                bl    = (t / BLINK_DIV) % 2;
                blank = (cnt < BLANK_CYC) || (page_en == 3'b000) || (bl == 1 && blink_mask[dig]);
                e.seg = blank ? 8'hFF : page_seg[(mpage * DIGITS + dig) * 8 +: 8];
                e.an  = blank ? 4'hF : (4'hF ^ (4'b0001 << dig));
                old   = mpage;
                lim   = (dwell_sec == 0) ? 1 : int'(dwell_sec);
                if (page_sel_valid && page_sel < PAGES && page_en[page_sel]) begin
                    mpage = page_sel; mdwell = 0;
                end else if (page_en == 3'b000) begin
                    mdwell = 0;
                end else if (!page_en[mpage]) begin
                    mpage = next_en(mpage, page_en); mdwell = 0;
                end else if ((t % SEC_DIV) == SEC_DIV - 1 && !hold) begin
                    if (mdwell == lim - 1) begin
                        mpage = next_en(mpage, page_en); mdwell = 0;
                    end else begin
                        mdwell = mdwell + 1;
                    end
                end
                e.page = mpage[1:0];
                e.chg  = (mpage != old);
                exp_q.push_back(e);
                t++;
            end
        end
    end

    // Monitor: one registered output word per clock, compared on the falling edge.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (rst_n && exp_q.size() > 0) begin
                e = exp_q.pop_front();
                pops++;
                check("seg", seg, e.seg);
                check("an", an, e.an);
                check("cur_page", cur_page, e.page);
                check("page_changed", page_changed, e.chg);
            end
        end
    end

    task automatic cycles(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic jump(input logic [1:0] p);
        page_sel_valid = 1'b1;
        page_sel       = p;
        @(negedge clk);
        page_sel_valid = 1'b0;
    endtask

    task automatic reset_pulse(input string tag);
        @(negedge clk);
        #1 rst_n = 1'b0;
        #1;
        check({tag, "_rst_seg"}, seg, 8'hFF);
        check({tag, "_rst_an"}, an, 4'hF);
        check({tag, "_rst_chg"}, page_changed, 0);
        check({tag, "_rst_page"}, cur_page, 0);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        int n;
        page_seg       = {$urandom, $urandom, $urandom};
        page_seg[31:0] = 32'hB0A4F9C0;
        page_en        = 3'b111;
        dwell_sec      = 4'd2;
        hold           = 1'b0;
        page_sel_valid = 1'b0;
        page_sel       = 2'd0;
        blink_mask     = 4'b0000;

        // Power-on reset
        #1 rst_n = 1'b0;
        #2;
        check("por_seg", seg, 8'hFF);
        check("por_an", an, 4'hF);
        check("por_page", cur_page, 0);
        @(negedge clk);
        rst_n = 1'b1;

        // Plain scanning of all three pages
        cycles(60);

        // Two enabled pages, dwell of 2 ticks
        reset_pulse("dwell");
        page_en = 3'b101;
        n = 0;
        repeat (65) begin
            @(negedge clk);
            if (page_changed) n++;
        end
        check("dwell_pulses", n, 3);
        check("dwell_page", cur_page, 2);

        // Jump while held; out-of-range request ignored
        page_en = 3'b111;
        hold    = 1'b1;
        jump(2'd1);
        check("jump_page", cur_page, 1);
        cycles(50);
        jump(2'd3);
        cycles(50);
        check("hold_page", cur_page, 1);

        // Current page disabled together with a jump to a disabled page
        page_en        = 3'b001;
        page_sel_valid = 1'b1;
        page_sel       = 2'd2;
        @(negedge clk);
        page_sel_valid = 1'b0;
        check("disable_page", cur_page, 0);
        cycles(10);

        // Blink on digit 0, then nothing enabled
        hold       = 1'b0;
        page_en    = 3'b111;
        blink_mask = 4'b0001;
        cycles(40);
        page_en = 3'b000;
        n = 0;
        repeat (20) begin
            @(negedge clk);
            if (an == 4'hF) n++;
        end
        check("empty_an", n, 20);
        blink_mask = 4'b0000;

        // Reset mid-dwell on page 2, full dwell must restart on page 0
        page_en = 3'b111;
        reset_pulse("pre");
        cycles(3);
        jump(2'd2);
        cycles(12);
        check("mid_page", cur_page, 2);
        reset_pulse("mid");
        cycles(19);
        check("restart_hold", cur_page, 0);
        cycles(1);
        check("restart_adv", cur_page, 1);

        // Randomised traffic
        for (int r = 0; r < 2; r++) begin
            dwell_sec = 4'($urandom_range(0, 3));
            reset_pulse("rnd");
            for (int i = 0; i < 300; i++) begin
                if ($urandom_range(0, 19) == 0) page_en = 3'($urandom_range(0, 7));
                if ($urandom_range(0, 29) == 0) hold = ~hold;
                if ($urandom_range(0, 39) == 0) blink_mask = 4'($urandom);
                if ($urandom_range(0, 49) == 0) page_seg = {$urandom, $urandom, $urandom};
                page_sel_valid = ($urandom_range(0, 14) == 0);
                page_sel       = 2'($urandom_range(0, 3));
                @(negedge clk);
            end
            page_sel_valid = 1'b0;
            hold           = 1'b0;
        end

        cycles(2);
        check("sb_active", int'(pops > 800), 1);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/fnd_page_scanner.md
FND_PAGE_SCANNER -- requirements
Module: fnd_page_scanner

Interface
REQ-001 Parameter DIGITS, default 4: number of multiplexed digits, legal range 2..8.
REQ-002 Parameter PAGES, default 2: number of display pages, legal range 1..4.
REQ-003 Parameter SCAN_DIV, default 100_000: clk cycles per digit slot.
REQ-004 Parameter BLANK_CYC, default 16: anti-ghost blank cycles at the start of each slot; must be less than SCAN_DIV.
REQ-005 Parameter SEC_DIV, default 100_000_000: clk cycles per dwell tick.
REQ-006 Parameter BLINK_DIV, default 50_000_000: clk cycles per blink phase.
REQ-007 clk  in  1  system clock; one clock domain only.
REQ-008 reset  in  1  asynchronous, active-low reset.
REQ-009 page_seg  in  PAGES*DIGITS*8  raw segment codes, active-low; page p, digit d at bits [(p*DIGITS+d)*8 +: 8].
REQ-010 page_en  in  PAGES  page enable mask; only enabled pages are shown.
REQ-011 dwell_sec  in  4  dwell ticks per page; 0 is treated as 1.
REQ-012 hold  in  1  freezes page rotation while high.
REQ-013 page_sel_valid  in  1  one-cycle request to jump to page_sel.
REQ-014 page_sel  in  max(1,clog2(PAGES))  requested page index.
REQ-015 blink_mask  in  DIGITS  digits that blink.
REQ-016 seg  out  8  active-low segment outputs, registered.
REQ-017 an  out  DIGITS  active-low digit enables, registered, at most one low.
REQ-018 cur_page  out  max(1,clog2(PAGES))  index of the page currently displayed.
REQ-019 page_changed  out  1  one-cycle pulse whenever cur_page changes.

Function
REQ-020 The scan counter SHALL count 0..SCAN_DIV-1; at the terminal count, the digit index advances and wraps from DIGITS-1 to 0.
REQ-021 When the scan counter is below BLANK_CYC, an SHALL be all ones and seg SHALL be 8'hFF.
REQ-022 Otherwise, seg SHALL equal page_seg[cur_page][digit] and an SHALL be low for that digit only.
REQ-023 seg and an SHALL have a latency of exactly one clk from the scan counter, digit index and cur_page.
REQ-024 While the blink phase is 1 and blink_mask[digit] is 1, the digit SHALL be blanked (an all ones, seg 8'hFF).
  - The blink phase toggles every BLINK_DIV cycles and starts at 0.
REQ-025 The tick counter SHALL count 0..SEC_DIV-1 free-running; it is not affected by hold.
REQ-026 The dwell counter SHALL increment on each tick while hold is low; hold high freezes the dwell counter.
REQ-027 On a tick with dwell counter equal to max(dwell_sec,1)-1, the block SHALL:
  - advance cur_page to the next enabled page above it, wrapping to 0;
  - clear the dwell counter.
REQ-028 If that page is the only enabled page, cur_page SHALL remain unchanged and page_changed SHALL stay low.
REQ-029 A page_sel_valid request with page_en[page_sel]=1 SHALL:
  - load cur_page on the next clk, even while hold is high;
  - clear the dwell counter.
  A request for a disabled page, or for a page_sel value of PAGES or above, SHALL be ignored.
REQ-030 If page_en[cur_page] goes to 0, the block SHALL advance to the next enabled page on the next clk and clear the dwell counter, even while hold is high.
REQ-031 When several page updates occur in the same cycle, priority SHALL be: jump request > disabled-page advance > dwell expiry.
REQ-032 If page_en is all zero:
  - an SHALL be all ones and seg SHALL be 8'hFF;
  - cur_page holds, the dwell counter is cleared, and scanning continues.
REQ-033 page_changed SHALL be registered and aligned with the clk edge on which cur_page updates.
REQ-034 All counters SHALL be sized to clog2 of their modulus and never exceed the modulus.

Reset
REQ-035 Asserting reset SHALL, asynchronously:
  - clear every counter, the digit index, the blink phase and cur_page;
  - drive an to all ones, seg to 8'hFF and page_changed to 0.
REQ-036 After release, the first unblanked digit SHALL be digit 0 of page 0, shown from cycle BLANK_CYC+1.
REQ-037 A reset asserted mid-slot or mid-dwell SHALL discard all progress.

Structure
REQ-038 A shared package SHALL hold:
  - SEG_BLANK = 8'hFF;
  - the active-low digit decode function;
  - the next-enabled-page search function.
REQ-039 The block SHALL contain one sub-module, fnd_tick_div: a parametrised modulo-N counter with a terminal-count pulse, instantiated for scan, tick and blink.

Verification
All scenarios use DIGITS=4, PAGES=3, SCAN_DIV=4, BLANK_CYC=1, SEC_DIV=10, BLINK_DIV=8.
REQ-040 Scan with page_en=3'b111, dwell_sec=2 and page 0 codes C0,F9,A4,B0:
  - expected repeating an pattern per 4-cycle slot: 1111,1110,1110,1110, then the same for 1101, 1011, 0111;
  - seg shows C0 for digit 0.
REQ-041 Dwell: page_en=3'b101, dwell_sec=2 -> cur_page sequence 0,2,0 with a change every 20 cycles and one page_changed pulse per change.
REQ-042 Jump and hold: with hold=1, page_sel_valid for page 1 -> cur_page=1 on the next clk; no further change for 100 cycles; page_sel=3 is ignored.
REQ-043 Disable current page: with cur_page=1, set page_en to 3'b001 -> cur_page=0 on the next clk; the simultaneous jump to page 2 is ignored.
REQ-044 Blink and empty: blink_mask=4'b0001 -> digit 0 is blanked during alternate 8-cycle phases; page_en=0 -> an=1111 on every cycle.
REQ-045 Reset asserted mid-dwell on page 2 -> outputs go to blank immediately; after release, cur_page=0 and the full dwell restarts.
